time_win_gen: RTL and testbench

TIME_WIN_GEN -- requirements
Module: time_win_gen

---
 rtl/time_win_gen.sv | 190 +++++++++++++++++++
 tb/tb_time_win_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/time_win_gen.sv
// time_win_gen: eight-channel time-window request tracker.
//
// A request (channel, initial window) is accepted when the target channel is
// idle, otherwise it is refused and counted. Pending windows count down by one
// on every tick (one clk in TICK_DIV) and stop at 0. A legal one-hot grant from
// the downstream selector retires its channel and is recorded for one cycle on
// gnt_valid/gnt_ch/gnt_win.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ch/in_win    offered request; in_ready = target channel idle
//   grant_in, gnt_en         one-hot grant and its enable
//   req_flag                 per-channel pending flags
//   time_win1..time_win8     current window of channels 0..7 (8'hFF when idle)
//   expired                  pending with window 0
//   gnt_valid/gnt_ch/gnt_win registered record of a served grant
//   drop_cnt                 saturating count of refused requests
//   err_gnt                  sticky illegal-grant flag

// Per-channel state: IDLE/PEND with its countdown window.
module time_win_chan (
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
    input  logic [7:0] load_win,
    input  logic       tick,
    input  logic       grant,
    output logic       pend,
    output logic [7:0] win
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] win_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            win   <= 8'hFF;
        end else begin
            state <= state_nxt;
            win   <= win_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_nxt   = win;
        case (state)
            IDLE: begin
                win_nxt = 8'hFF;
                if (accept) begin
                    state_nxt = PEND;
                    win_nxt   = load_win;
                end
            end
            PEND: begin
                // A grant wins over a same-cycle tick: the channel leaves with
                // the window it had, so the decrement is moot.
                if (grant) begin
                    state_nxt = IDLE;
                    win_nxt   = 8'hFF;
                end else if (tick && (win != 8'd0)) begin
                    win_nxt = win - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                win_nxt   = 8'hFF;
            end
        endcase
    end

    assign pend = (state == PEND);
endmodule

module time_win_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_ch,
    input  logic [7:0] in_win,
    output logic       in_ready,
    input  logic [7:0] grant_in,
    input  logic       gnt_en,
    output logic [7:0] req_flag,
    output logic [7:0] time_win1,
    output logic [7:0] time_win2,
    output logic [7:0] time_win3,
    output logic [7:0] time_win4,
    output logic [7:0] time_win5,
    output logic [7:0] time_win6,
    output logic [7:0] time_win7,
    output logic [7:0] time_win8,
    output logic [7:0] expired,
    output logic       gnt_valid,
    output logic [2:0] gnt_ch,
    output logic [7:0] gnt_win,
    output logic [7:0] drop_cnt,
    output logic       err_gnt
);
    localparam int NUM_CH = 8;
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    logic [NUM_CH-1:0][7:0] win;
    logic [7:0]             tick_cnt;
    logic                   tick;
    logic                   accept, refuse;
    logic [NUM_CH-1:0]      accept_vec;
    logic                   gnt_onehot, gnt_hits_pend, gnt_legal, gnt_bad;
    logic [NUM_CH-1:0]      gnt_vec;
    logic [2:0]             gnt_idx;

    // Free-running tick divider; tick fires on the last count of each period.
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst)       tick_cnt <= 8'd0;
        else if (tick) tick_cnt <= 8'd0;
        else           tick_cnt <= tick_cnt + 8'd1;
    end

    // Readiness looks only at the pending flag, never at a same-cycle grant,
    // so a request racing a grant on its own channel is refused.
    assign in_ready   = ~req_flag[in_ch];
    assign accept     = in_valid & in_ready;
    assign refuse     = in_valid & ~in_ready;
    assign accept_vec = accept ? (NUM_CH'(1) << in_ch) : '0;

    assign gnt_onehot    = (grant_in != 8'd0) && ((grant_in & (grant_in - 8'd1)) == 8'd0);
    assign gnt_hits_pend = |(grant_in & req_flag);
    assign gnt_legal     = gnt_en && gnt_onehot && gnt_hits_pend;
    // An all-zero grant is simply "nothing this cycle", not an error.
    assign gnt_bad       = gnt_en && (grant_in != 8'd0) && !(gnt_onehot && gnt_hits_pend);
    assign gnt_vec       = gnt_legal ? grant_in : '0;

    always_comb begin
        gnt_idx = 3'd0;
        for (int i = 0; i < NUM_CH; i++)
            if (grant_in[i]) gnt_idx = 3'(i);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            time_win_chan u_ch (
                .clk      (clk),
                .rst      (rst),
                .accept   (accept_vec[g]),
                .load_win (in_win),
                .tick     (tick),
                .grant    (gnt_vec[g]),
                .pend     (req_flag[g]),
                .win      (win[g])
            );
            assign expired[g] = req_flag[g] & (win[g] == 8'd0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_valid <= 1'b0;
            gnt_ch    <= 3'd0;
            gnt_win   <= 8'd0;
            drop_cnt  <= 8'd0;
            err_gnt   <= 1'b0;
        end else begin
            gnt_valid <= gnt_legal;
            if (gnt_legal) begin
                gnt_ch  <= gnt_idx;
                gnt_win <= win[gnt_idx];   // register value, before any tick
            end
            if (refuse && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
            if (gnt_bad)
                err_gnt <= 1'b1;
        end
    end

    assign time_win1 = win[0];
    assign time_win2 = win[1];
    assign time_win3 = win[2];
    assign time_win4 = win[3];
    assign time_win5 = win[4];
    assign time_win6 = win[5];
    assign time_win7 = win[6];
    assign time_win8 = win[7];
endmodule

// File: tb/tb_time_win_gen.sv
module tb_time_win_gen;
    localparam int TD = 4;

    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, gnt_en = 1'b0;
    logic [2:0] in_ch = 3'd0;
    logic [7:0] in_win = 8'd0, grant_in = 8'd0;
    logic       in_ready, gnt_valid, err_gnt;
    logic [7:0] req_flag, expired, gnt_win, drop_cnt;
    logic [2:0] gnt_ch;
    logic [7:0] tw1, tw2, tw3, tw4, tw5, tw6, tw7, tw8;
    logic [7:0] tw [8];

    typedef struct {logic [2:0] ch; logic [7:0] win;} gnt_t;
    gnt_t sb[$];

    int n_tests = 0, n_fail = 0;
    int ph = 0;   // bench's own tick phase: next edge is a tick edge when ph == TD-1

    time_win_gen #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_win(in_win),
        .in_ready(in_ready), .grant_in(grant_in), .gnt_en(gnt_en), .req_flag(req_flag),
        .time_win1(tw1), .time_win2(tw2), .time_win3(tw3), .time_win4(tw4),
        .time_win5(tw5), .time_win6(tw6), .time_win7(tw7), .time_win8(tw8),
        .expired(expired), .gnt_valid(gnt_valid), .gnt_ch(gnt_ch), .gnt_win(gnt_win),
        .drop_cnt(drop_cnt), .err_gnt(err_gnt)
    );

    assign tw[0] = tw1; assign tw[1] = tw2; assign tw[2] = tw3; assign tw[3] = tw4;
    assign tw[4] = tw5; assign tw[5] = tw6; assign tw[6] = tw7; assign tw[7] = tw8;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        ph = rst ? 0 : (ph + 1) % TD;
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_ch = 3'd0; in_win = 8'd0; grant_in = 8'd0; gnt_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_tick();
        for (int i = 0; i < TD && ph != TD - 1; i++) step();
    endtask

    task automatic offer(input logic [2:0] ch, input logic [7:0] w);
        in_valid = 1'b1; in_ch = ch; in_win = w;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (req_flag !== 8'h00) begin n_fail++; $display("FAIL reset_req_flag got %h want 00", req_flag); end
        for (int k = 0; k < 8; k++) begin
            n_tests++; if (tw[k] !== 8'hFF) begin n_fail++; $display("FAIL reset_win%0d got %h want FF", k, tw[k]); end
        end
        n_tests++; if (expired !== 8'h00) begin n_fail++; $display("FAIL reset_expired got %h want 00", expired); end
        n_tests++; if ({gnt_valid, gnt_ch, gnt_win} !== 12'h000) begin n_fail++; $display("FAIL reset_gnt got %b/%0d/%h want 0/0/00", gnt_valid, gnt_ch, gnt_win); end
        n_tests++; if (drop_cnt !== 8'd0 || err_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err got %0d/%b want 0/0", drop_cnt, err_gnt); end
        for (int k = 0; k < 8; k++) begin
            in_ch = 3'(k); #1;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready ch%0d got %b want 1", k, in_ready); end
        end
        in_ch = 3'd0;
    endtask

    task automatic test_countdown();
        logic [7:0] prev;
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'd2; exp_seq[1] = 8'd1; exp_seq[2] = 8'd0; exp_seq[3] = 8'd0;
        do_reset();
        offer(3'd2, 8'd3);
        n_tests++; if (req_flag !== 8'h04 || tw[2] !== 8'd3) begin n_fail++; $display("FAIL countdown_load got %h/%0d want 04/3", req_flag, tw[2]); end
        prev = 8'd3;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            n_tests++; if (tw[2] !== prev) begin n_fail++; $display("FAIL countdown_hold%0d got %0d want %0d", i, tw[2], prev); end
            step();
            n_tests++; if (tw[2] !== exp_seq[i]) begin n_fail++; $display("FAIL countdown_tick%0d got %0d want %0d", i, tw[2], exp_seq[i]); end
            prev = exp_seq[i];
        end
        n_tests++; if (expired !== 8'h04 || req_flag !== 8'h04) begin n_fail++; $display("FAIL countdown_expired got %h/%h want 04/04", expired, req_flag); end
    endtask

    task automatic test_drop();
        do_reset();
        offer(3'd5, 8'd0);   // window 0 accepted, so it is expired and frozen at 0
        n_tests++; if (expired !== 8'h20 || tw[5] !== 8'd0) begin n_fail++; $display("FAIL drop_zero_win got %h/%0d want 20/0", expired, tw[5]); end
        in_valid = 1'b1; in_ch = 3'd5; in_win = 8'd9; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drop_in_ready got %b want 0", in_ready); end
        step();
        n_tests++; if (drop_cnt !== 8'd1 || tw[5] !== 8'd0) begin n_fail++; $display("FAIL drop_first got %0d/%0d want 1/0", drop_cnt, tw[5]); end
        for (int i = 0; i < 299; i++) step();
        idle_inputs();
        n_tests++; if (drop_cnt !== 8'd255 || req_flag !== 8'h20) begin n_fail++; $display("FAIL drop_saturate got %0d/%h want 255/20", drop_cnt, req_flag); end
    endtask

    task automatic test_grant_tick();
        gnt_t g;
        do_reset();
        offer(3'd1, 8'd7);
        offer(3'd3, 8'd10);
        wait_tick();
        grant_in = 8'h02; gnt_en = 1'b1;
        g.ch = 3'd1; g.win = 8'd7; sb.push_back(g);
        step();
        idle_inputs();
        n_tests++;
        if (gnt_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL grant_tick_valid got %b want 1", gnt_valid);
        end else begin
            g = sb.pop_front();
            n_tests++; if (gnt_ch !== g.ch || gnt_win !== g.win) begin n_fail++; $display("FAIL grant_tick_rec got %0d/%0d want %0d/%0d", gnt_ch, gnt_win, g.ch, g.win); end
        end
        n_tests++; if (req_flag !== 8'h08 || tw[1] !== 8'hFF || tw[3] !== 8'd9) begin n_fail++; $display("FAIL grant_tick_state got %h/%h/%0d want 08/FF/9", req_flag, tw[1], tw[3]); end
        step();
        n_tests++; if (gnt_valid !== 1'b0 || gnt_ch !== 3'd1 || gnt_win !== 8'd7) begin n_fail++; $display("FAIL grant_tick_after got %b/%0d/%0d want 0/1/7", gnt_valid, gnt_ch, gnt_win); end
    endtask

    task automatic test_back_to_back();
        gnt_t g;
        do_reset();
        offer(3'd0, 8'd4);               // ph 0 -> 1
        in_valid = 1'b1; in_ch = 3'd0; in_win = 8'd5;
        grant_in = 8'h01; gnt_en = 1'b1; #1;
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
        g.ch = 3'd0; g.win = 8'd4; sb.push_back(g);
        step();                          // ph 1 -> 2, no tick
        idle_inputs();
        n_tests++;
        if (gnt_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL b2b_valid got %b want 1", gnt_valid);
        end else begin
            g = sb.pop_front();
            n_tests++; if (gnt_ch !== g.ch || gnt_win !== g.win) begin n_fail++; $display("FAIL b2b_rec got %0d/%0d want %0d/%0d", gnt_ch, gnt_win, g.ch, g.win); end
        end
        n_tests++; if (drop_cnt !== 8'd1 || req_flag !== 8'h00) begin n_fail++; $display("FAIL b2b_drop got %0d/%h want 1/00", drop_cnt, req_flag); end
        in_valid = 1'b1; in_ch = 3'd0; in_win = 8'd5; #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_retry_ready got %b want 1", in_ready); end
        step();                          // ph 2 -> 3
        idle_inputs();
        n_tests++; if (req_flag !== 8'h01 || tw[0] !== 8'd5) begin n_fail++; $display("FAIL b2b_retry got %h/%0d want 01/5", req_flag, tw[0]); end
        // Tick edge: grant ch0 while ch4 is accepted in the same cycle.
        in_valid = 1'b1; in_ch = 3'd4; in_win = 8'd6;
        grant_in = 8'h01; gnt_en = 1'b1;
        g.ch = 3'd0; g.win = 8'd5; sb.push_back(g);
        step();
        idle_inputs();
        n_tests++;
        if (gnt_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++; $display("FAIL b2b_dual_valid got %b want 1", gnt_valid);
        end else begin
            g = sb.pop_front();
            n_tests++; if (gnt_ch !== g.ch || gnt_win !== g.win) begin n_fail++; $display("FAIL b2b_dual_rec got %0d/%0d want %0d/%0d", gnt_ch, gnt_win, g.ch, g.win); end
        end
        n_tests++; if (req_flag !== 8'h10 || tw[4] !== 8'd6 || tw[0] !== 8'hFF) begin n_fail++; $display("FAIL b2b_dual_state got %h/%0d/%h want 10/6/FF", req_flag, tw[4], tw[0]); end
    endtask

    task automatic test_illegal_grant();
        do_reset();
        offer(3'd1, 8'd50);
        offer(3'd2, 8'd50);
        grant_in = 8'h02; gnt_en = 1'b0; step();
        n_tests++; if (gnt_valid !== 1'b0 || req_flag !== 8'h06 || err_gnt !== 1'b0) begin n_fail++; $display("FAIL ill_disabled got %b/%h/%b want 0/06/0", gnt_valid, req_flag, err_gnt); end
        grant_in = 8'h00; gnt_en = 1'b1; step();
        n_tests++; if (gnt_valid !== 1'b0 || err_gnt !== 1'b0) begin n_fail++; $display("FAIL ill_zero got %b/%b want 0/0", gnt_valid, err_gnt); end
        grant_in = 8'h06; gnt_en = 1'b1; step();
        idle_inputs();
        n_tests++; if (gnt_valid !== 1'b0 || req_flag !== 8'h06 || err_gnt !== 1'b1) begin n_fail++; $display("FAIL ill_multi got %b/%h/%b want 0/06/1", gnt_valid, req_flag, err_gnt); end
        for (int i = 0; i < 5; i++) step();
        n_tests++; if (err_gnt !== 1'b1) begin n_fail++; $display("FAIL ill_sticky got %b want 1", err_gnt); end
        do_reset();
        n_tests++; if (err_gnt !== 1'b0) begin n_fail++; $display("FAIL ill_clear got %b want 0", err_gnt); end
        offer(3'd3, 8'd20);
        grant_in = 8'h20; gnt_en = 1'b1; step();
        idle_inputs();
        n_tests++; if (gnt_valid !== 1'b0 || req_flag !== 8'h08 || err_gnt !== 1'b1) begin n_fail++; $display("FAIL ill_idle got %b/%h/%b want 0/08/1", gnt_valid, req_flag, err_gnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        offer(3'd0, 8'd30);
        offer(3'd3, 8'd31);
        offer(3'd7, 8'd32);
        in_valid = 1'b1; in_ch = 3'd6; in_win = 8'd9;   // dropped with the reset
        grant_in = 8'h01; gnt_en = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        n_tests++; if (req_flag !== 8'h00 || expired !== 8'h00) begin n_fail++; $display("FAIL midrst_flags got %h/%h want 00/00", req_flag, expired); end
        for (int k = 0; k < 8; k++) begin
            n_tests++; if (tw[k] !== 8'hFF) begin n_fail++; $display("FAIL midrst_win%0d got %h want FF", k, tw[k]); end
        end
        n_tests++; if ({gnt_valid, gnt_ch, gnt_win} !== 12'h000 || drop_cnt !== 8'd0 || err_gnt !== 1'b0) begin n_fail++; $display("FAIL midrst_regs got %b/%0d/%h/%0d/%b want 0/0/00/0/0", gnt_valid, gnt_ch, gnt_win, drop_cnt, err_gnt); end
        // Tick counter restarted: first tick lands TD edges after reset.
        offer(3'd2, 8'd8);
        for (int i = 1; i < TD; i++) step();
        n_tests++; if (tw[2] !== 8'd7) begin n_fail++; $display("FAIL midrst_tick_phase got %0d want 7", tw[2]); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_drop();
        test_grant_tick();
        test_back_to_back();
        test_illegal_grant();
        test_mid_reset();
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
